fetch_ctrl: RTL and testbench

- Controller that owns the 16-bit, byte-addressed instruction memory (instr_memory, combinational read: pc in, instr out). Word addresses are even.
- Serialises two users of that memory:
  - a program loader that streams words into memory from address 0;
  - the fetch stage, which steps the PC and hands registered instructions to decode with stall, branch-redirect and halt handling.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/load_sequencer.sv | 52 +++++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller: FSM encoding, widths, PC step.
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

endpackage

// File: rtl/load_sequencer.sv
// Program-load write path: walks the byte address from 0 in word steps,
// drives the instruction-memory write port and flags the final word.
module load_sequencer
    import fetch_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_active_i,
    input  logic               load_clear_i,
    input  logic               ld_valid_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    input  logic               ld_last_i,
    output logic               ld_ready_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_waddr_o,
    output logic [INSTR_W-1:0] mem_wdata_o,
    output logic               load_done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 2);

    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic              accept;

    assign accept      = load_active_i & ld_valid_i;
    assign ld_ready_o  = load_active_i;
    assign mem_we_o    = accept;
    assign mem_waddr_o = load_addr_q;
    assign mem_wdata_o = load_active_i ? ld_data_i : '0;
    // The load ends on the marked word or when the top word is filled; no wrap.
    assign load_done_o = accept & (ld_last_i | (load_addr_q == LAST_ADDR));

    // Next write address: restart at 0 on entry to load, step per accepted word.
    always_comb begin
        load_addr_d = load_addr_q;
        if (load_clear_i)
            load_addr_d = '0;
        else if (accept)
            load_addr_d = load_addr_q + PC_STEP;
    end

    // Write-address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_addr_q <= '0;
        else
            load_addr_q <= load_addr_d;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: arbitrates the instruction memory between the program
// loader and the fetch stage, which steps the PC and hands registered
// instructions to decode with stall, branch redirect and halt handling.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [3:0]        HALT_OP   = 4'h9,
    parameter int                MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ld_req,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0]  mem_pc,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               halted
);

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [ADDR_W-1:0]  if_pc_q;
    logic               if_valid_q;
    logic               halted_q;
    logic               load_done;
    logic               enter_load;

    // ld_req is only honoured when fetch is not running.
    assign enter_load = ld_req & ((state_q == IDLE) | (state_q == HALT));

    load_sequencer #(
        .MEM_BYTES (MEM_BYTES)
    ) u_load_seq (
        .clk           (clk),
        .rst           (rst),
        .load_active_i (state_q == LOAD),
        .load_clear_i  (enter_load),
        .ld_valid_i    (ld_valid),
        .ld_data_i     (ld_data),
        .ld_last_i     (ld_last),
        .ld_ready_o    (ld_ready),
        .mem_we_o      (mem_we),
        .mem_waddr_o   (mem_waddr),
        .mem_wdata_o   (mem_wdata),
        .load_done_o   (load_done)
    );

    // The single read port follows the load address during a load, else the PC.
    assign mem_pc   = (state_q == LOAD) ? mem_waddr : pc_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;
    assign halted   = halted_q;

    // Main FSM with registered fetch outputs; branch beats stall beats normal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_req) begin
                        state_q <= LOAD;
                    end else if (start) begin
                        state_q <= RUN;
                        pc_q    <= RESET_PC;
                    end
                end
                LOAD: begin
                    if (load_done)
                        state_q <= IDLE;
                end
                RUN: begin
                    if (branch_taken) begin
                        pc_q       <= branch_target & 16'hFFFE;
                        if_valid_q <= 1'b0;
                    end else if (!stall) begin
                        if_instr_q <= mem_instr;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        // The halt word is still delivered; the PC parks on it.
                        if (mem_instr[15:12] == HALT_OP) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + PC_STEP;
                        end
                    end
                end
                HALT: begin
                    if (!stall)
                        if_valid_q <= 1'b0;
                    if (ld_req) begin
                        state_q  <= LOAD;
                        halted_q <= 1'b0;
                    end else if (start) begin
                        state_q  <= RUN;
                        pc_q     <= RESET_PC;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a behavioural instruction memory.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, ld_req = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0;
    logic [15:0] ld_data = '0, branch_target = '0;
    logic        ld_ready, mem_we, if_valid, halted;
    logic [15:0] mem_waddr, mem_wdata, mem_pc, mem_instr, if_instr, if_pc;

    logic [15:0] imem [0:127] = '{default: 16'h0000};
    logic [15:0] prog [0:3]   = '{16'h24c2, 16'h2101, 16'h0748, 16'h9000};

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ld_req(ld_req),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_instr(mem_instr),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) imem[mem_waddr[7:1]] <= mem_wdata;
    assign mem_instr = imem[mem_pc[7:1]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (if_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: if_valid=%b halted=%b want 0 0", if_valid, halted); end
        checks++; if (if_instr !== 16'h0 || if_pc !== 16'h0) begin errors++; $display("FAIL reset_if: instr=%h pc=%h want 0 0", if_instr, if_pc); end
        checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_ld: ready=%b we=%b want 0 0", ld_ready, mem_we); end
        checks++; if (mem_waddr !== 16'h0 || mem_wdata !== 16'h0 || mem_pc !== 16'h0) begin errors++; $display("FAIL reset_mem: waddr=%h wdata=%h pc=%h want 0 0 0", mem_waddr, mem_wdata, mem_pc); end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_load;
        exp_t e;
        ld_req = 1'b1;
        tick;
        ld_req = 1'b0;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready_up: got %b want 1", ld_ready); end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == 3);
            sb.push_back('{a: 16'(2 * i), d: prog[i]});
            #1;
            checks++;
            if (!mem_we) begin
                errors++; $display("FAIL load_we word %0d: got 0 want 1", i);
            end else begin
                e = sb.pop_front();
                if (mem_waddr !== e.a || mem_wdata !== e.d) begin
                    errors++; $display("FAIL load_write word %0d: got %h/%h want %h/%h", i, mem_waddr, mem_wdata, e.a, e.d);
                end
            end
            tick;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL load_ready_down: got %b want 0", ld_ready); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL load_pending: got %0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_run;
        exp_t e;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL run_first_valid: got %b want 0", if_valid); end
        for (int i = 0; i < 4; i++) sb.push_back('{a: 16'(2 * i), d: prog[i]});
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (!if_valid) begin
                errors++; $display("FAIL run_valid cycle %0d: got 0 want 1", i);
            end else begin
                e = sb.pop_front();
                if (if_pc !== e.a || if_instr !== e.d) begin
                    errors++; $display("FAIL run_fetch cycle %0d: got %h/%h want %h/%h", i, if_pc, if_instr, e.a, e.d);
                end
            end
        end
        sb.delete();
        tick;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL run_halted: got %b want 1", halted); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL run_halt_valid: got %b want 0", if_valid); end
        checks++; if (mem_pc !== 16'h0006) begin errors++; $display("FAIL run_halt_pc: got %h want 0006", mem_pc); end
    endtask

    task automatic test_stall;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        checks++; if (if_pc !== 16'h0002) begin errors++; $display("FAIL stall_setup: if_pc=%h want 0002", if_pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (if_pc !== 16'h0002 || if_instr !== 16'h2101 || if_valid !== 1'b1 || mem_pc !== 16'h0004) begin
                errors++; $display("FAIL stall_hold %0d: got pc=%h instr=%h v=%b mem_pc=%h want 0002 2101 1 0004", i, if_pc, if_instr, if_valid, mem_pc);
            end
        end
        stall = 1'b0;
        tick;
        checks++; if (if_pc !== 16'h0004 || if_instr !== 16'h0748) begin errors++; $display("FAIL stall_resume: got %h/%h want 0004/0748", if_pc, if_instr); end
        tick;
        tick;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL stall_end_halt: got %b want 1", halted); end
    endtask

    task automatic test_branch_stall;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0005;
        tick;
        stall        = 1'b0;
        branch_taken = 1'b0;
        checks++; if (if_valid !== 1'b0 || mem_pc !== 16'h0004) begin errors++; $display("FAIL branch_flush: got v=%b pc=%h want 0 0004", if_valid, mem_pc); end
        tick;
        checks++; if (if_pc !== 16'h0004 || if_instr !== 16'h0748 || if_valid !== 1'b1) begin errors++; $display("FAIL branch_fetch: got %h/%h v=%b want 0004/0748 1", if_pc, if_instr, if_valid); end
        tick;
        checks++; if (halted !== 1'b1 || if_pc !== 16'h0006) begin errors++; $display("FAIL branch_halt: got halted=%b pc=%h want 1 0006", halted, if_pc); end
        branch_taken  = 1'b1;
        branch_target = 16'h0000;
        tick;
        branch_taken = 1'b0;
        checks++; if (mem_pc !== 16'h0006 || halted !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_ignores_branch: got pc=%h h=%b v=%b want 0006 1 0", mem_pc, halted, if_valid); end
    endtask

    task automatic test_reset_midload;
        ld_req = 1'b1;
        tick;
        ld_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            tick;
        end
        ld_data = prog[2];
        rst = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_load: ready=%b we=%b want 0 0", ld_ready, mem_we); end
        checks++; if (mem_waddr !== 16'h0 || halted !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rst_state: waddr=%h h=%b v=%b want 0 0 0", mem_waddr, halted, if_valid); end
        ld_valid = 1'b0;
        tick;
        rst = 1'b0;
        test_load();
    endtask

    task automatic test_simultaneous;
        ld_req = 1'b1;
        start  = 1'b1;
        tick;
        ld_req = 1'b0;
        start  = 1'b0;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL simul_load: ready=%b want 1", ld_ready); end
        ld_valid = 1'b1;
        ld_data  = prog[0];
        ld_last  = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_waddr !== 16'h0) begin errors++; $display("FAIL simul_write: we=%b addr=%h want 1 0000", mem_we, mem_waddr); end
        tick;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL simul_done: ready=%b v=%b want 0 0", ld_ready, if_valid); end
    endtask

    task automatic test_wrap;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        branch_taken  = 1'b1;
        branch_target = 16'hFFFE;
        tick;
        branch_taken = 1'b0;
        checks++; if (mem_pc !== 16'hFFFE || if_valid !== 1'b0) begin errors++; $display("FAIL wrap_redirect: pc=%h v=%b want FFFE 0", mem_pc, if_valid); end
        tick;
        checks++; if (if_pc !== 16'hFFFE || if_instr !== 16'h0000 || mem_pc !== 16'h0000) begin errors++; $display("FAIL wrap_step: if_pc=%h instr=%h mem_pc=%h want FFFE 0000 0000", if_pc, if_instr, mem_pc); end
        tick;
        checks++; if (if_pc !== 16'h0000 || if_instr !== 16'h24c2) begin errors++; $display("FAIL wrap_next: got %h/%h want 0000/24c2", if_pc, if_instr); end
        tick;
        tick;
        tick;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wrap_halt: got %b want 1", halted); end
    endtask

    task automatic test_load_boundary;
        exp_t e;
        ld_req = 1'b1;
        tick;
        ld_req = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'h5A00 ^ 16'(i);
            sb.push_back('{a: 16'(2 * i), d: 16'h5A00 ^ 16'(i)});
            #1;
            checks++;
            if (!mem_we) begin
                errors++; $display("FAIL bound_we word %0d: got 0 want 1", i);
            end else begin
                e = sb.pop_front();
                if (mem_waddr !== e.a || mem_wdata !== e.d) begin
                    errors++; $display("FAIL bound_write word %0d: got %h/%h want %h/%h", i, mem_waddr, mem_wdata, e.a, e.d);
                end
            end
            tick;
        end
        checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL bound_end: ready=%b we=%b want 0 0", ld_ready, mem_we); end
        ld_valid = 1'b0;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_stall();
        test_branch_stall();
        test_reset_midload();
        test_simultaneous();
        test_wrap();
        test_load_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
